// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared types and constants for the RV32M multiply/divide unit
package mul_div_unit_pkg;
  localparam int MULDIV_ITERS = 32;
  typedef logic [31:0] word;
  typedef logic [4:0] reg_index;
  typedef enum logic {READ_REG_DATA, WRITE_REG_DATA} reg_file_op_t;
  typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} muldiv_op_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add (mul) or restoring shift-subtract (div) iteration on {hi, lo}; ports is_div_i, hi_i/lo_i accumulator, opnd_i multiplicand/divisor, hi_o/lo_o next accumulator
module muldiv_step
  import mul_div_unit_pkg::*;
(
  input  logic is_div_i,
  input  word  hi_i,
  input  word  lo_i,
  input  word  opnd_i,
  output word  hi_o,
  output word  lo_o
);
  logic [32:0] sum, sh, diff;
  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : 33'd0);
    sh   = {hi_i, lo_i[31]};
    diff = sh - {1'b0, opnd_i};
    hi_o = is_div_i ? (diff[32] ? sh[31:0] : diff[31:0]) : sum[32:1];
    lo_o = is_div_i ? {lo_i[30:0], ~diff[32]} : {sum[0], lo_i[31:1]};
  end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M mul/div unit (clock, reset, start/op/rs1_data/rs2_data/rd/kill in; busy/done/result/rd_out/mem_op out); MULDIV_FAST_MUL_EN enables a single-cycle multiplier
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  muldiv_op_t   op,
  input  word          rs1_data,
  input  word          rs2_data,
  input  reg_index     rd,
  input  logic         kill,
  output logic         busy,
  output logic         done,
  output word          result,
  output reg_index     rd_out,
  output reg_file_op_t mem_op
);
  localparam int N  = MULDIV_ITERS / STEPS_PER_CYCLE;
  localparam int CW = $clog2(N);
  muldiv_state_t state_q;
  muldiv_op_t op_q;
  word hi_q, lo_q, opnd_q, result_q, mag1, mag2, fast_res, res_d, qr;
  reg_index rd_q;
  reg_file_op_t mem_op_q;
  logic neg_q, busy_q, done_q, s1, s2, is_div, is_rem, neg_d, dz, ovf, fast;
  logic [CW-1:0] cnt_q;
  logic [63:0] prod;
  word hi_c [STEPS_PER_CYCLE+1];
  word lo_c [STEPS_PER_CYCLE+1];
`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fprod;
`endif
  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;
  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    muldiv_step u_step (
      .is_div_i(op_q[2]),
      .hi_i    (hi_c[i]),
      .lo_i    (lo_c[i]),
      .opnd_i  (opnd_q),
      .hi_o    (hi_c[i+1]),
      .lo_o    (lo_c[i+1])
    );
  end
  always_comb begin
    is_div   = op[2];
    is_rem   = op[2] & op[1];
    s1       = is_div ? ~op[0] : op != MULHU;
    s2       = is_div ? ~op[0] : op == MUL || op == MULH;
    mag1     = s1 && rs1_data[31] ? -rs1_data : rs1_data;
    mag2     = s2 && rs2_data[31] ? -rs2_data : rs2_data;
    neg_d    = is_rem ? s1 & rs1_data[31] : (s1 & rs1_data[31]) ^ (s2 & rs2_data[31]);
    dz       = rs2_data == '0;
    ovf      = s1 && rs1_data == 32'h8000_0000 && rs2_data == '1;
    fast     = is_div & (dz | ovf);
    fast_res = is_rem ? (dz ? rs1_data : '0) : (dz ? '1 : 32'h8000_0000);
`ifdef MULDIV_FAST_MUL_EN
    fprod    = 64'($signed({s1 & rs1_data[31], rs1_data})) * 64'($signed({s2 & rs2_data[31], rs2_data}));
    fast     = is_div ? fast : 1'b1;
    fast_res = is_div ? fast_res : (op == MUL ? fprod[31:0] : fprod[63:32]);
`endif
    prod  = neg_q ? -{hi_c[STEPS_PER_CYCLE], lo_c[STEPS_PER_CYCLE]} : {hi_c[STEPS_PER_CYCLE], lo_c[STEPS_PER_CYCLE]};
    qr    = op_q[1] ? hi_c[STEPS_PER_CYCLE] : lo_c[STEPS_PER_CYCLE];
    res_d = op_q[2] ? (neg_q ? -qr : qr) : (op_q == MUL ? prod[31:0] : prod[63:32]);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      mem_op_q <= READ_REG_DATA;
    end else if (kill) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mem_op_q <= READ_REG_DATA;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= fast ? DONE : CALC;
          busy_q  <= 1'b1;
          done_q  <= fast;
          op_q    <= op;
          rd_q    <= rd;
          neg_q   <= neg_d;
          cnt_q   <= '0;
          hi_q    <= '0;
          lo_q    <= is_div ? mag1 : mag2;
          opnd_q  <= is_div ? mag2 : mag1;
          if (fast) begin
            result_q <= fast_res;
            mem_op_q <= rd != '0 ? WRITE_REG_DATA : READ_REG_DATA;
          end
        end
        CALC: begin
          hi_q  <= hi_c[STEPS_PER_CYCLE];
          lo_q  <= lo_c[STEPS_PER_CYCLE];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= res_d;
            mem_op_q <= rd_q != '0 ? WRITE_REG_DATA : READ_REG_DATA;
          end
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          mem_op_q <= READ_REG_DATA;
        end
      endcase
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_q;
  assign mem_op = mem_op_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  logic clock = 0, reset = 1, start = 0, kill = 0;
  muldiv_op_t op = MUL;
  word rs1_data = '0, rs2_data = '0;
  reg_index rd = '0;
  logic busy, done;
  word result;
  reg_index rd_out;
  reg_file_op_t mem_op;
  int checks = 0, errors = 0, lat, seen;
  always #5 clock = ~clock;
  mul_div_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd), .kill(kill),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .mem_op(mem_op)
  );
  task automatic check(input string tag, input word obs, input word exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run(input muldiv_op_t o, input word a, input word b, input reg_index r);
    @(negedge clock);
    start = 1; op = o; rs1_data = a; rs2_data = b; rd = r;
    @(posedge clock); #1 start = 0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clock); #1 lat++;
    end
  endtask
  task automatic run_chk(input string tag, input muldiv_op_t o, input word a, input word b,
                         input reg_index r, input int exp_lat, input word exp_res);
    run(o, a, b, r);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, result, exp_res);
    @(posedge clock); #1;
    check({tag, " busy after"}, 32'(busy), 32'd0);
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 0;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst result", result, 32'd0);
    check("rst rd_out", 32'(rd_out), 32'd0);
    check("rst mem_op", 32'(mem_op), 32'(READ_REG_DATA));
    run(DIVU, 32'd100, 32'd7, 5'd5);
    check("divu done", 32'(done), 32'd1);
    check("divu latency", lat, 33);
    check("divu result", result, 32'd14);
    check("divu mem_op", 32'(mem_op), 32'(WRITE_REG_DATA));
    check("divu rd_out", 32'(rd_out), 32'd5);
    @(posedge clock); #1;
    check("divu busy after", 32'(busy), 32'd0);
    check("divu done after", 32'(done), 32'd0);
    check("divu mem_op after", 32'(mem_op), 32'(READ_REG_DATA));
    run_chk("remu", REMU, 32'd100, 32'd7, 5'd5, 33, 32'd2);
    run_chk("div neg", DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 33, 32'hFFFF_FFFD);
    run_chk("rem neg", REM, 32'hFFFF_FFF9, 32'd2, 5'd1, 33, 32'hFFFF_FFFF);
    run_chk("div by 0", DIV, 32'h1234, 32'd0, 5'd2, 1, 32'hFFFF_FFFF);
    run_chk("rem by 0", REM, 32'h1234, 32'd0, 5'd2, 1, 32'h1234);
    run_chk("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1, 32'h8000_0000);
    run_chk("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1, 32'd0);
    run_chk("mul", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, MUL_LAT, 32'd1);
    run_chk("mulh", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, MUL_LAT, 32'd0);
    run_chk("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, MUL_LAT, 32'hFFFF_FFFE);
    run_chk("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, MUL_LAT, 32'hFFFF_FFFF);
    run_chk("mulhsu mixed", MULHSU, 32'hFFFF_FFFE, 32'd3, 5'd4, MUL_LAT, 32'hFFFF_FFFF);
    run_chk("mul large", MUL, 32'h0001_0001, 32'h0001_0001, 5'd4, MUL_LAT, 32'h0002_0001);
    run_chk("mulhu large", MULHU, 32'h8000_0000, 32'h0000_0004, 5'd4, MUL_LAT, 32'd2);
    @(negedge clock);
    start = 1; op = DIVU; rs1_data = 32'd200; rs2_data = 32'd10; rd = 5'd6;
    @(posedge clock); #1 start = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    start = 1; op = DIV; rs1_data = 32'h1234; rs2_data = 32'd0; rd = 5'd7;
    @(posedge clock); #1 start = 0;
    lat = 4;
    while (!done && lat < 40) begin
      @(posedge clock); #1 lat++;
    end
    check("busy start latency", lat, 33);
    check("busy start result", result, 32'd20);
    check("busy start rd_out", 32'(rd_out), 32'd6);
    @(posedge clock); #1;
    @(negedge clock);
    start = 1; op = DIVU; rs1_data = 32'd100; rs2_data = 32'd7; rd = 5'd5;
    @(posedge clock); #1 start = 0;
    seen = 0;
    repeat (9) begin
      @(posedge clock); #1 seen += int'(done);
    end
    kill = 1;
    @(posedge clock); #1 kill = 0;
    check("kill busy", 32'(busy), 32'd0);
    check("kill done", 32'(done), 32'd0);
    check("kill no early done", seen, 0);
    run_chk("after kill", DIVU, 32'd50, 32'd5, 5'd8, 33, 32'd10);
    @(negedge clock);
    start = 1; kill = 1; op = DIV; rs1_data = 32'h1234; rs2_data = 32'd0; rd = 5'd9;
    @(posedge clock); #1 start = 0; kill = 0;
    seen = int'(busy) + int'(done);
    repeat (3) begin
      @(posedge clock); #1 seen += int'(busy) + int'(done);
    end
    check("start+kill ignored", seen, 0);
    run(MUL, 32'd3, 32'd4, 5'd0);
    check("rd0 done", 32'(done), 32'd1);
    check("rd0 latency", lat, MUL_LAT);
    check("rd0 result", result, 32'd12);
    check("rd0 mem_op", 32'(mem_op), 32'(READ_REG_DATA));
    @(posedge clock); #1;
    @(negedge clock);
    start = 1; op = DIVU; rs1_data = 32'd99; rs2_data = 32'd3; rd = 5'd9;
    @(posedge clock); #1 start = 0;
    repeat (4) @(posedge clock);
    #1 reset = 1;
    @(posedge clock); #1 reset = 0;
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst done", 32'(done), 32'd0);
    check("mid rst result", result, 32'd0);
    check("mid rst rd_out", 32'(rd_out), 32'd0);
    check("mid rst mem_op", 32'(mem_op), 32'(READ_REG_DATA));
    seen = 0;
    repeat (35) begin
      @(posedge clock); #1 seen += int'(done);
    end
    check("mid rst no done", seen, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
